// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS datapath.
// Define FAST_MULT_EN to replace the shift-add multiplier with a single-cycle combinational one.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_rs, r_hi, r_lo, w_abs_a, w_abs_b, w_q, w_r;
  logic [2*WIDTH-1:0] r_p, w_p_next, w_mul_p, w_div_p, w_res;
  logic [WIDTH:0] w_rem_sh, w_tr;
  logic [CW-1:0] r_cnt;
  logic r_neg_q, r_neg_r, r_bz, r_done, w_fin, w_last, w_mul_fin, w_sa, w_sb;
  assign w_sa = ~op[0] & rs_data[WIDTH-1];
  assign w_sb = ~op[0] & rt_data[WIDTH-1];
  assign w_abs_a = w_sa ? -rs_data : rs_data;
  assign w_abs_b = w_sb ? -rt_data : rt_data;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // Restoring step: trial-subtract the divisor from the shifted partial remainder; bit WIDTH is the borrow.
  assign w_rem_sh = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_tr = w_rem_sh - {1'b0, r_b};
  assign w_div_p = w_tr[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0} : {w_tr[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
  assign w_q = w_div_p[WIDTH-1:0];
  assign w_r = w_div_p[2*WIDTH-1:WIDTH];
`ifdef FAST_MULT_EN
  assign w_mul_p = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_mul_fin = 1'b1;
`else
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_mul_p = {w_sum, r_p[WIDTH-1:1]};
  assign w_mul_fin = w_last;
`endif
  always_comb begin
    w_state_next = r_state;
    w_p_next = r_state == DIV ? w_div_p : w_mul_p;
    w_fin = (r_state == DIV && w_last) || (r_state == MUL && w_mul_fin);
    w_res = r_state == DIV ? (r_bz ? {r_rs, {WIDTH{1'b1}}}
                                   : {r_neg_r ? -w_r : w_r, r_neg_q ? -w_q : w_q})
                           : (r_neg_q ? -w_mul_p : w_mul_p);
    if (r_state == IDLE && start) w_state_next = op[1] ? DIV : MUL;
    else if (w_fin) w_state_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_fin;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (start) begin
          r_a     <= w_abs_a;
          r_b     <= w_abs_b;
          r_rs    <= rs_data;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_bz    <= rt_data == '0;
          r_p     <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
        end else begin
          if (mthi) r_hi <= rs_data;
          if (mtlo) r_lo <= rs_data;
        end
      end else begin
        r_p   <= w_p_next;
        r_cnt <= w_fin ? '0 : r_cnt + 1'b1;
        if (w_fin) {r_hi, r_lo} <= w_res;
      end
    end
  end
  assign hi = r_hi;
  assign lo = r_lo;
  assign busy = r_state != IDLE;
  assign done = r_done;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench with an arithmetic reference model for mult_div_unit.
module tb_mult_div_unit;
  logic clk = 0, rst = 1, start = 0, mthi = 0, mtlo = 0;
  logic [1:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0, hi, lo;
  logic busy, done;
  int n_chk = 0, n_err = 0, cyc = 0;
`ifdef FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  typedef struct {logic [31:0] hi, lo; int cyc;} exp_t;
  exp_t sb[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0: return longint'($signed(a)) * longint'($signed(b));
      2'd1: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    exp_t e;
    r = model(o, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.cyc = cyc + 1 + (o[1] ? 32 : MUL_LAT);
    sb.push_back(e);
    op = o; rs_data = a; rt_data = b; start = 1;
    @(posedge clk); #1;
    start = 0; rs_data = $urandom; rt_data = $urandom;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_timeout", busy, 0);
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL spurious_done: done=1 expected 0");
      end else begin
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_hi", hi, 0); check("rst_lo", lo, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    issue(1, 5, 15); wait_idle();
    issue(0, 32'hFFFFFFFE, 3); wait_idle();
    issue(1, 32'hFFFFFFFE, 3); wait_idle();
    issue(2, 32'hFFFFFFF9, 2); wait_idle();
    issue(3, 15, 2); wait_idle();
    issue(3, 5, 0); wait_idle();
    issue(2, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    issue(2, 32'hFFFFFFF0, 0); wait_idle();
    issue(0, 32'h80000000, 32'h80000000); wait_idle();
    issue(3, 15, 2);
    repeat (8) begin @(posedge clk); #1; end
    op = 1; rs_data = 5; rt_data = 15; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    mthi = 1; rs_data = 32'h1234;
    @(posedge clk); #1 mthi = 0;
    wait_idle();
    mthi = 1; rs_data = 32'hCAFE0001;
    @(posedge clk); #1 mthi = 0;
    check("mthi_hi", hi, 32'hCAFE0001); check("mthi_lo", lo, 7);
    mthi = 1; mtlo = 1; rs_data = 32'h5A5A1234;
    @(posedge clk); #1 mthi = 0; mtlo = 0;
    check("mthilo_hi", hi, 32'h5A5A1234); check("mthilo_lo", lo, 32'h5A5A1234);
    mthi = 1; mtlo = 1;
    issue(3, 100, 7);
    mthi = 0; mtlo = 0;
    check("start_wins_hi", hi, 32'h5A5A1234);
    wait_idle();
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(o, a, b);
      wait_idle();
    end
    issue(2, 32'hFFFF0000, 7);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    void'(sb.pop_back());
    check("abort_hi", hi, 0); check("abort_lo", lo, 0);
    check("abort_busy", busy, 0); check("abort_done", done, 0);
    repeat (40) begin @(posedge clk); #1; end
    mtlo = 1; rs_data = 32'hABCD;
    @(posedge clk); #1 mtlo = 0;
    check("mtlo_lo", lo, 32'hABCD); check("mtlo_hi", hi, 0); check("mtlo_done", done, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
